// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-look-ahead adder among NREQ
// requesters, with a single-entry valid/ready result register.

module carry_look_ahead_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g_s, p_s;
  logic [16:0] c_s;
  logic [3:0]  gg_s, gp_s;
  logic [4:0]  gc_s;

  // Two-level look-ahead: 4-bit group generate/propagate, then group carries.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gc_s = 5'b0;
    c_s  = 17'b0;
    for (int j = 0; j < 4; j++) begin
      gg_s[j] = g_s[4*j+3]
              | (p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
              | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      gp_s[j] = &p_s[4*j +: 4];
    end
    gc_s[0] = cin;
    for (int j = 0; j < 4; j++) begin
      gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
    end
    for (int j = 0; j < 4; j++) begin
      c_s[4*j] = gc_s[j];
      for (int k = 0; k < 3; k++) begin
        c_s[4*j+k+1] = g_s[4*j+k] | (p_s[4*j+k] & c_s[4*j+k]);
      end
    end
    c_s[16] = gc_s[4];
    sum     = p_s ^ c_s[15:0];
    cout    = c_s[16];
  end
endmodule

module cla_adder_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready
);
  logic [IDW-1:0] ptr_r;
  logic           res_valid_r;
  logic [W-1:0]   res_data_r;
  logic [IDW-1:0] res_id_r;
  logic           slot_free_s;
  logic           hit_s;
  logic [IDW-1:0] gnt_idx_s;
  logic [IDW-1:0] ptr_next_s;
  logic [IDW-1:0] cand_s [NREQ];
  logic [W-1:0]   a_sel_s, b_sel_s, sum_s;
  logic           cout_s;

  assign slot_free_s = !res_valid_r || res_ready;

  for (genvar k = 0; k < NREQ; k++) begin : g_cand
    assign cand_s[k] = IDW'((32'(ptr_r) + k) % NREQ);
  end

  // Scan from the pointer; the loop runs backwards so the nearest request wins.
  always_comb begin
    hit_s     = 1'b0;
    gnt_idx_s = '0;
    if (slot_free_s && rst_n) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req[cand_s[k]]) begin
          hit_s     = 1'b1;
          gnt_idx_s = cand_s[k];
        end else begin
          hit_s     = hit_s;
        end
      end
    end else begin
      hit_s = 1'b0;
    end
  end

  assign gnt        = hit_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s) : '0;
  assign ptr_next_s = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + 1'b1;
  assign a_sel_s    = a_flat[int'(gnt_idx_s)*W +: W];
  assign b_sel_s    = b_flat[int'(gnt_idx_s)*W +: W];

  carry_look_ahead_adder u_add (
    .a    (a_sel_s),
    .b    (b_sel_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Result slot and round-robin pointer; a grant refills even while popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= '0;
      ptr_r       <= '0;
    end else if (hit_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= sum_s;
      res_id_r    <= gnt_idx_s;
      ptr_r       <= ptr_next_s;
    end else if (res_valid_r && res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;

  logic unused_s;
  assign unused_s = cout_s;
endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed, table-driven bench for cla_adder_arbiter (NREQ=4, W=16).

module tb_cla_adder_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] a_flat, b_flat;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;

  int n_cmp = 0;
  int n_err = 0;

  cla_adder_arbiter #(.NREQ(4), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic        vld;
    logic [15:0] data;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive at negedge, check combinational grant, then registered result after the edge.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] eg,
                      input logic ev, input logic [15:0] ed, input logic [1:0] eid,
                      input string tag);
    @(negedge clk);
    req = r;
    res_ready = rdy;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(res_valid), 32'(ev));
    chk({tag, ".data"}, 32'(res_data), 32'(ed));
    chk({tag, ".id"}, 32'(res_id), 32'(eid));
  endtask

  initial begin
    // A0+B0=2221, A1+B1=0100, A2+B2=0000 (carry dropped), A3+B3=0001 (carry dropped)
    a_flat = {16'h8000, 16'hFFFF, 16'h00FF, 16'h1234};
    b_flat = {16'h8001, 16'h0001, 16'h0001, 16'h0FED};
    rst_n = 1'b0;
    req = 4'b0000;
    res_ready = 1'b1;

    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 16'h2221, 2'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2221, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'h0000, 2'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'h0001, 2'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h2221, 2'd0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1};
    tbl[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 16'h0001, 2'd3};
    tbl[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 16'h2221, 2'd0};
    tbl[9]  = '{4'b1100, 1'b0, 4'b0000, 1'b1, 16'h2221, 2'd0};
    tbl[10] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 16'h0000, 2'd2};
    tbl[11] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'h0100, 2'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0100, 2'd1};
    tbl[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 16'h0000, 2'd2};
    tbl[15] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 16'h2221, 2'd0};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2221, 2'd0};

    // Reset held for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("rst.gnt", 32'(gnt), 32'd0);
      chk("rst.valid", 32'(res_valid), 32'd0);
    end
    chk("rst.data", 32'(res_data), 32'd0);
    chk("rst.id", 32'(res_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].req, tbl[i].rdy, tbl[i].gnt, tbl[i].vld, tbl[i].data, tbl[i].id,
           $sformatf("vec%0d", i));
    end

    // Stall: fill slot, hold res_ready low for 5 cycles with req=0010, then pop+grant.
    step(4'b0001, 1'b0, 4'b0001, 1'b1, 16'h2221, 2'd0, "fill");
    for (int c = 0; c < 5; c++) begin
      step(4'b0010, 1'b0, 4'b0000, 1'b1, 16'h2221, 2'd0, $sformatf("stall%0d", c));
    end
    step(4'b0010, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, "popgnt");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0100, 2'd1, "drain");

    // Reset mid-operation with a pending result and a non-zero pointer.
    step(4'b0100, 1'b0, 4'b0100, 1'b1, 16'h0000, 2'd2, "prerst");
    @(negedge clk);
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(res_valid), 32'd0);
    chk("midrst.gnt", 32'(gnt), 32'd0);
    chk("midrst.id", 32'(res_id), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst.gnt2", 32'(gnt), 32'd0);
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    step(4'b1010, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, "postrst");
    step(4'b1010, 1'b1, 4'b1000, 1'b1, 16'h0001, 2'd3, "postrst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
